depth_stream_packer_fp16: RTL and testbench

Sits directly downstream of the dual-scale depth pipeline and consumes its z/c/col/row/valid pixel stream. Gates each depth value by a programmable FP16 confidence threshold and packs {c, z} into 32-bit beats. Buffers beats in a FIFO and emits them on a ready/valid stream with start-of-frame and end-of-line markers. Also reports a per-frame count of confident pixels. The upstream stage has no backpressure, so FIFO overflow is detected and flagged.

---
 rtl/dfdd_stream_pkg.sv | 46 ++++
 rtl/sync_fifo_fwft.sv | 68 ++++++
 rtl/depth_stream_packer_fp16.sv | 126 ++++++++++++
 tb/tb_depth_stream_packer_fp16.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfdd_stream_pkg.sv
// Shared FP16 types, beat layout and the confidence compare used by the depth stream packer.
package dfdd_stream_pkg;

   localparam int unsigned FP16_EXP_W  = 5;
   localparam int unsigned FP16_FRAC_W = 10;
   localparam int unsigned FP16_W      = 1 + FP16_EXP_W + FP16_FRAC_W;

   localparam logic [FP16_W-1:0] FP16_EXP_MASK = 16'h7C00;

   typedef logic [FP16_W-1:0] fp16_t;

   typedef struct packed {
      logic  sof;
      logic  eol;
      fp16_t c;
      fp16_t z;
   } beat_t;

   localparam int unsigned BEAT_W = $bits(beat_t);

   function automatic logic fp16_is_nan(input fp16_t v);
      return ((v & FP16_EXP_MASK) == FP16_EXP_MASK) && (v[FP16_FRAC_W-1:0] != '0);
   endfunction

   // a >= b; NaN on either side compares false, signed zeros compare equal.
   function automatic logic fp16_ge(input fp16_t a, input fp16_t b);
      logic [FP16_W-2:0] mag_a;
      logic [FP16_W-2:0] mag_b;
      logic              ge;
      mag_a = a[FP16_W-2:0];
      mag_b = b[FP16_W-2:0];
      if (fp16_is_nan(a) || fp16_is_nan(b)) begin
         ge = 1'b0;
      end else if ((mag_a == '0) && (mag_b == '0)) begin
         ge = 1'b1;
      end else if (a[FP16_W-1] != b[FP16_W-1]) begin
         ge = !a[FP16_W-1];
      end else if (!a[FP16_W-1]) begin
         ge = (mag_a >= mag_b);
      end else begin
         ge = (mag_a <= mag_b);
      end
      return ge;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered output; the displayed head stays in the
// buffer until it is handed over, so DEPTH counts every entry including the one on the output.
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 1024
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic             o_full,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_rd_valid,
   input  logic             i_rd_ready
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;

   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic [AW:0]      w_rptr_nxt;
   logic             w_avail;

   always_comb begin
      w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
      w_pop      = r_out_valid && i_rd_ready;
      w_push     = i_wr_en && (!w_full || w_pop);
      w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};
      // Only entries already in memory are eligible; a same-cycle write shows up next cycle.
      w_avail    = (r_wptr != w_rptr_nxt);
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         r_rptr      <= w_rptr_nxt;
         r_out_valid <= w_avail;
         if (w_avail) begin
            r_out_data <= r_mem[w_rptr_nxt[AW-1:0]];
         end
      end
   end

   assign o_full     = w_full;
   assign o_rd_data  = r_out_data;
   assign o_rd_valid = r_out_valid;

endmodule

// File: rtl/depth_stream_packer_fp16.sv
// Gates depth by FP16 confidence, packs {c, z} beats into a FWFT FIFO with SOF/EOL markers,
// and reports a per-frame confident-pixel count plus a sticky drop flag.
module depth_stream_packer_fp16
   import dfdd_stream_pkg::*;
#(
   parameter int unsigned EXP_WIDTH    = 5,
   parameter int unsigned FRAC_WIDTH   = 10,
   parameter int unsigned IMAGE_WIDTH  = 4,
   parameter int unsigned IMAGE_HEIGHT = 2,
   parameter int unsigned FIFO_DEPTH   = 1024,
   localparam int unsigned FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [FP_WIDTH_REG-1:0]   z_i,
   input  logic [FP_WIDTH_REG-1:0]   c_i,
   input  logic [15:0]               col_i,
   input  logic [15:0]               row_i,
   input  logic                      valid_i,
   input  logic [FP_WIDTH_REG-1:0]   c_thresh_i,
   input  logic [FP_WIDTH_REG-1:0]   z_invalid_i,
   output logic [2*FP_WIDTH_REG-1:0] m_data_o,
   output logic                      m_valid_o,
   input  logic                      m_ready_i,
   output logic                      m_user_o,
   output logic                      m_last_o,
   output logic                      overflow_o,
   output logic [31:0]               conf_count_o,
   output logic                      conf_count_valid_o
);

   localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
   localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

   logic                    r_s1_valid;
   logic                    r_s1_conf;
   logic                    r_s1_sof;
   logic                    r_s1_eol;
   logic                    r_s1_eof;
   logic [FP_WIDTH_REG-1:0] r_s1_c;
   logic [FP_WIDTH_REG-1:0] r_s1_z;

   logic [31:0]             r_cnt;
   logic [31:0]             r_conf_count;
   logic                    r_conf_count_vld;
   logic                    r_overflow;

   logic                    w_conf;
   logic                    w_fifo_full;
   logic                    w_accept;
   logic [31:0]             w_base;
   logic [31:0]             w_sum;
   beat_t                   w_wr_beat;
   beat_t                   w_rd_beat;

   always_comb begin
      w_conf    = fp16_ge(c_i, c_thresh_i);
      w_accept  = !w_fifo_full || (m_valid_o && m_ready_i);
      w_wr_beat = '{sof: r_s1_sof, eol: r_s1_eol, c: r_s1_c, z: r_s1_z};
      // A start-of-frame pixel restarts the count even if the previous frame was partial.
      w_base    = r_s1_sof ? 32'd0 : r_cnt;
      w_sum     = w_base;
      if (r_s1_valid && r_s1_conf && !(&w_base)) begin
         w_sum = w_base + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1_valid       <= 1'b0;
         r_s1_conf        <= 1'b0;
         r_s1_sof         <= 1'b0;
         r_s1_eol         <= 1'b0;
         r_s1_eof         <= 1'b0;
         r_s1_c           <= '0;
         r_s1_z           <= '0;
         r_cnt            <= '0;
         r_conf_count     <= '0;
         r_conf_count_vld <= 1'b0;
         r_overflow       <= 1'b0;
      end else begin
         r_s1_valid       <= valid_i;
         r_s1_conf        <= w_conf;
         r_s1_sof         <= (row_i == 16'd0) && (col_i == 16'd0);
         r_s1_eol         <= (col_i == LAST_COL);
         r_s1_eof         <= (row_i == LAST_ROW) && (col_i == LAST_COL);
         r_s1_c           <= c_i;
         r_s1_z           <= w_conf ? z_i : z_invalid_i;
         r_conf_count_vld <= 1'b0;
         if (r_s1_valid) begin
            if (r_s1_eof) begin
               r_conf_count     <= w_sum;
               r_conf_count_vld <= 1'b1;
               r_cnt            <= '0;
            end else begin
               r_cnt <= w_sum;
            end
            if (!w_accept) begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   sync_fifo_fwft #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_wr_en    (r_s1_valid),
      .i_wr_data  (w_wr_beat),
      .o_full     (w_fifo_full),
      .o_rd_data  (w_rd_beat),
      .o_rd_valid (m_valid_o),
      .i_rd_ready (m_ready_i)
   );

   assign m_data_o           = {w_rd_beat.c, w_rd_beat.z};
   assign m_user_o           = w_rd_beat.sof;
   assign m_last_o           = w_rd_beat.eol;
   assign overflow_o         = r_overflow;
   assign conf_count_o       = r_conf_count;
   assign conf_count_valid_o = r_conf_count_vld;

endmodule

// File: tb/tb_depth_stream_packer_fp16.sv
// Directed bench: a 4x2 image driven into two packers (FIFO depth 16 and depth 4) sharing inputs.
module tb_depth_stream_packer_fp16;

   logic        clk;
   logic        rst;
   logic [15:0] z, c, col, row, c_thresh, z_invalid;
   logic        valid;
   logic        rdy_a, rdy_b;

   logic [31:0] md_a, md_b, cc_a, cc_b;
   logic        mv_a, mu_a, ml_a, ov_a, ccv_a;
   logic        mv_b, mu_b, ml_b, ov_b, ccv_b;

   logic [33:0] qa[$];
   logic [33:0] qb[$];
   int          pulses_a;
   int          checks;
   int          errors;

   depth_stream_packer_fp16 #(
      .IMAGE_WIDTH  (4),
      .IMAGE_HEIGHT (2),
      .FIFO_DEPTH   (16)
   ) dut_a (
      .clk_i              (clk),
      .rst_i              (rst),
      .z_i                (z),
      .c_i                (c),
      .col_i              (col),
      .row_i              (row),
      .valid_i            (valid),
      .c_thresh_i         (c_thresh),
      .z_invalid_i        (z_invalid),
      .m_data_o           (md_a),
      .m_valid_o          (mv_a),
      .m_ready_i          (rdy_a),
      .m_user_o           (mu_a),
      .m_last_o           (ml_a),
      .overflow_o         (ov_a),
      .conf_count_o       (cc_a),
      .conf_count_valid_o (ccv_a)
   );

   depth_stream_packer_fp16 #(
      .IMAGE_WIDTH  (4),
      .IMAGE_HEIGHT (2),
      .FIFO_DEPTH   (4)
   ) dut_b (
      .clk_i              (clk),
      .rst_i              (rst),
      .z_i                (z),
      .c_i                (c),
      .col_i              (col),
      .row_i              (row),
      .valid_i            (valid),
      .c_thresh_i         (c_thresh),
      .z_invalid_i        (z_invalid),
      .m_data_o           (md_b),
      .m_valid_o          (mv_b),
      .m_ready_i          (rdy_b),
      .m_user_o           (mu_b),
      .m_last_o           (ml_b),
      .overflow_o         (ov_b),
      .conf_count_o       (cc_b),
      .conf_count_valid_o (ccv_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial pulses_a = 0;
   always @(posedge clk) begin
      if (!rst && mv_a && rdy_a) qa.push_back({mu_a, ml_a, md_a});
      if (!rst && mv_b && rdy_b) qb.push_back({mu_b, ml_b, md_b});
      if (ccv_a) pulses_a = pulses_a + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_px(input logic [15:0] r, input logic [15:0] cl, input logic [15:0] cv,
                           input logic [15:0] zv);
      row   = r;
      col   = cl;
      c     = cv;
      z     = zv;
      valid = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   // Even pixels confident (1.0 >= 0.5), odd pixels not (0.25), z = 2.0.
   task automatic send_std_frame();
      for (int p = 0; p < 8; p++) begin
         drive_px(16'(p / 4), 16'(p % 4), p[0] ? 16'h3400 : 16'h3C00, 16'h4000);
         if (p == 1) check("latency_not_yet", mv_a, 1'b0);
         if (p == 2) begin
            check("latency_valid", mv_a, 1'b1);
            check("latency_data", md_a, 32'h3C004000);
         end
      end
      idle(6);
   endtask

   task automatic check_std_frame(input int base, input int p0);
      logic [33:0] e;
      check("frame_beats", qa.size() - base, 8);
      for (int i = 0; i < 8; i++) begin
         e[33]   = (i == 0);
         e[32]   = ((i % 4) == 3);
         e[31:0] = (i % 2 == 1) ? 32'h34000000 : 32'h3C004000;
         check($sformatf("frame_beat%0d", i), qa[base + i], e);
      end
      check("frame_conf_count", cc_a, 32'd4);
      check("frame_conf_pulses", pulses_a - p0, 1);
   endtask

   logic [15:0] t_th  [8] = '{16'h3800, 16'h3800, 16'h0000, 16'hBC00,
                              16'hBC00, 16'h7C01, 16'h0000, 16'h3C00};
   logic [15:0] t_c   [8] = '{16'h3800, 16'h7E00, 16'h8000, 16'hC000,
                              16'hB800, 16'h3C00, 16'h7C00, 16'hFC00};
   logic [15:0] t_z   [8] = '{16'h1234, 16'h1234, 16'h1111, 16'h2222,
                              16'h3333, 16'h4444, 16'h5555, 16'h6666};
   logic [31:0] t_exp [8] = '{32'h38001234, 32'h7E00ABCD, 32'h80001111, 32'hC000ABCD,
                              32'hB8003333, 32'h3C00ABCD, 32'h7C005555, 32'hFC00ABCD};

   initial begin
      int base;
      int p0;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      valid     = 1'b0;
      z         = '0;
      c         = '0;
      col       = '0;
      row       = '0;
      c_thresh  = 16'h3800;
      z_invalid = 16'h0000;
      rdy_a     = 1'b1;
      rdy_b     = 1'b1;
      idle(2);
      check("rst_m_valid", mv_a, 1'b0);
      check("rst_m_data", md_a, 32'h0);
      check("rst_m_user", mu_a, 1'b0);
      check("rst_m_last", ml_a, 1'b0);
      check("rst_overflow", ov_a, 1'b0);
      check("rst_conf_count", cc_a, 32'h0);
      check("rst_conf_valid", ccv_a, 1'b0);
      check("rst_m_valid_b", mv_b, 1'b0);
      rst = 1'b0;
      idle(2);

      // Basic frame.
      base = qa.size();
      p0   = pulses_a;
      send_std_frame();
      check_std_frame(base, p0);
      check("frame_no_overflow", ov_a, 1'b0);

      // Compare corner cases.
      z_invalid = 16'hABCD;
      for (int i = 0; i < 8; i++) begin
         c_thresh = t_th[i];
         base     = qa.size();
         drive_px(16'd0, 16'd1, t_c[i], t_z[i]);
         idle(4);
         check($sformatf("cmp%0d_beats", i), qa.size() - base, 1);
         check($sformatf("cmp%0d_beat", i), qa[base], {2'b00, t_exp[i]});
      end
      c_thresh  = 16'h3800;
      z_invalid = 16'h0000;

      // Ten-cycle downstream stall mid-line on the depth-16 instance.
      base = qa.size();
      drive_px(16'd0, 16'd0, 16'h3C00, 16'h0100);
      idle(4);
      rdy_a = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k <= 3) begin
            row   = 16'd0;
            col   = 16'(k);
            c     = 16'h3C00;
            z     = 16'h0100 + 16'(k);
            valid = 1'b1;
         end
         tick();
         valid = 1'b0;
         if (k >= 3) begin
            check($sformatf("stall%0d_valid", k), mv_a, 1'b1);
            check($sformatf("stall%0d_data", k), md_a, 32'h3C000101);
         end
      end
      rdy_a = 1'b1;
      idle(6);
      check("stall_beats", qa.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("stall_beat%0d", i), qa[base + i],
               {(i == 0), (i == 3), 16'h3C00, 16'h0100 + 16'(i)});
      end

      // Overflow on the depth-4 instance: 8 pixels, 4 kept; first 6 confident.
      rdy_b = 1'b0;
      for (int p = 0; p < 8; p++) begin
         drive_px(16'(p / 4), 16'(p % 4), (p < 6) ? 16'h3C00 : 16'h3400, 16'h0200 + 16'(p));
      end
      idle(6);
      check("ovf_b_set", ov_b, 1'b1);
      check("ovf_a_clear", ov_a, 1'b0);
      check("ovf_b_count", cc_b, 32'd6);
      check("ovf_a_count", cc_a, 32'd6);
      check("ovf_b_valid", mv_b, 1'b1);
      check("ovf_b_head", md_b, 32'h3C000200);
      check("ovf_b_head_user", mu_b, 1'b1);
      idle(3);
      check("ovf_b_sticky", ov_b, 1'b1);

      // Mid-frame reset with beats buffered in both instances.
      rdy_a = 1'b0;
      drive_px(16'd0, 16'd0, 16'h3C00, 16'h0300);
      drive_px(16'd0, 16'd1, 16'h3C00, 16'h0301);
      idle(3);
      check("pre_rst_a_valid", mv_a, 1'b1);
      rst = 1'b1;
      tick();
      check("mid_rst_a_valid", mv_a, 1'b0);
      check("mid_rst_b_valid", mv_b, 1'b0);
      check("mid_rst_a_data", md_a, 32'h0);
      check("mid_rst_b_data", md_b, 32'h0);
      check("mid_rst_b_user", mu_b, 1'b0);
      check("mid_rst_b_ovf", ov_b, 1'b0);
      check("mid_rst_a_count", cc_a, 32'h0);
      check("mid_rst_b_count", cc_b, 32'h0);
      rst   = 1'b0;
      rdy_a = 1'b1;
      rdy_b = 1'b1;
      idle(3);
      check("post_rst_empty", mv_a, 1'b0);
      base = qa.size();
      p0   = pulses_a;
      send_std_frame();
      check_std_frame(base, p0);

      // Depth-4 FIFO full, then a write lands in the same cycle as a read.
      base  = qb.size();
      rdy_b = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_px((i < 3) ? 16'd1 : 16'd0, (i < 3) ? 16'(i) : 16'(i - 2), 16'h3C00,
                  16'h0700 + 16'(i));
      end
      rdy_b = 1'b1;
      tick();
      check("same_cycle_no_ovf", ov_b, 1'b0);
      idle(8);
      check("same_cycle_beats", qb.size() - base, 5);
      check("same_cycle_first", qb[base][31:0], 32'h3C000700);
      check("same_cycle_last", qb[base + 4][31:0], 32'h3C000704);
      check("same_cycle_ovf_end", ov_b, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
